// File: rtl/aftab_opt_down_counter.sv
// Iteration down-counter for AFTAB multi-cycle units: load, subtract a 2-bit step per enabled cycle, pulse done.
// Optional macro AFTAB_DOWNCNT_SATURATE_EN clamps an underflowing terminal count to zero instead of wrapping.
module aftab_opt_down_counter #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clr,
    input  logic            en,
    input  logic [size-1:0] load_val,
    input  logic [1:0]      step,
    output logic [size-1:0] count,
    output logic            busy,
    output logic            done,
    output logic            borrow
);

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_run  = 2'd1,
        s_done = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [size-1:0] count_nxt;
    logic            borrow_nxt;
    logic [size:0]   diff;

    // Count written on the terminal cycle when step exceeds the remaining count.
    function automatic logic [size-1:0] underflow_count(input logic [size:0] d);
`ifdef AFTAB_DOWNCNT_SATURATE_EN
        underflow_count = '0;
`else
        underflow_count = d[size-1:0];
`endif
    endfunction

    // MSB of the widened difference is the borrow out of the decrement.
    assign diff = {1'b0, count} - {{(size-1){1'b0}}, step};

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        borrow_nxt = borrow;
        if (clr) begin
            state_nxt = s_idle;
        end else begin
            case (state)
                s_run: begin
                    if (en && step != 2'd0) begin
                        if (diff[size]) begin
                            state_nxt  = s_done;
                            borrow_nxt = 1'b1;
                            count_nxt  = underflow_count(diff);
                        end else if (diff[size-1:0] == '0) begin
                            state_nxt  = s_done;
                            borrow_nxt = 1'b0;
                            count_nxt  = '0;
                        end else begin
                            count_nxt = diff[size-1:0];
                        end
                    end
                end
                s_idle, s_done: begin
                    if (state == s_done) begin
                        state_nxt = s_idle;
                    end
                    if (start) begin
                        borrow_nxt = 1'b0;
                        if (load_val != '0) begin
                            state_nxt = s_run;
                            count_nxt = load_val;
                        end else begin
                            state_nxt = s_done;
                            count_nxt = '0;
                        end
                    end
                end
                default: state_nxt = s_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= s_idle;
            count  <= '0;
            borrow <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            borrow <= borrow_nxt;
        end
    end

    assign busy = (state == s_run);
    assign done = (state == s_done);

endmodule

// File: tb/tb_aftab_opt_down_counter.sv
// Bench for aftab_opt_down_counter (size=8): directed scenarios then random traffic against an arithmetic model.
module tb_aftab_opt_down_counter;

`ifdef AFTAB_DOWNCNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clr;
    logic       en;
    logic [7:0] load_val;
    logic [1:0] step;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       borrow;

    int nchecks;
    int nerr;

    // Model: remaining count, whether an operation is active, whether the completion pulse is showing.
    int m_count;
    int m_busy;
    int m_done;
    int m_borrow;

    aftab_opt_down_counter #(.size(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .clr     (clr),
        .en      (en),
        .load_val(load_val),
        .step    (step),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .borrow  (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},  32'(count),  32'(m_count));
        check({tag, ".busy"},   32'(busy),   32'(m_busy));
        check({tag, ".done"},   32'(done),   32'(m_done));
        check({tag, ".borrow"}, 32'(borrow), 32'(m_borrow));
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_busy   = 0;
        m_done   = 0;
        m_borrow = 0;
    endtask

    task automatic model_edge();
        int s;
        s = int'(step);
        if (clr) begin
            m_busy = 0;
            m_done = 0;
        end else if (m_busy != 0) begin
            if (en && s > 0) begin
                if (s >= m_count) begin
                    m_borrow = (s > m_count) ? 1 : 0;
                    m_count  = (SAT || m_borrow == 0) ? 0 : (m_count - s + 256);
                    m_busy   = 0;
                    m_done   = 1;
                end else begin
                    m_count = m_count - s;
                end
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_borrow = 0;
                if (load_val == 8'd0) begin
                    m_count = 0;
                    m_done  = 1;
                end else begin
                    m_count = int'(load_val);
                    m_busy  = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic s, input logic c, input logic e, input logic [7:0] lv, input logic [1:0] st);
        @(negedge clk);
        start    = s;
        clr      = c;
        en       = e;
        load_val = lv;
        step     = st;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic cyc(input string tag, input logic s, input logic c, input logic e,
                       input logic [7:0] lv, input logic [1:0] st);
        drive(s, c, e, lv, st);
        tick(tag);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        clr = 1'b0;
        en = 1'b0;
        load_val = 8'd0;
        step = 2'd0;
        nchecks = 0;
        nerr = 0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle", 0, 0, 1, 8'd7, 2'd1);

        // Reset in the middle of a run
        cyc("rst_load", 1, 0, 0, 8'd20, 2'd1);
        cyc("rst_r1", 0, 0, 1, 8'd0, 2'd1);
        cyc("rst_r2", 0, 0, 1, 8'd0, 2'd1);
        cyc("rst_r3", 0, 0, 1, 8'd0, 2'd1);
        check("rst_pre_count", 32'(count), 32'd17);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        check("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exact countdown 12 by 3
        cyc("exact_load", 1, 0, 1, 8'd12, 2'd3);
        check("exact_load_count", 32'(count), 32'd12);
        cyc("exact_1", 0, 0, 1, 8'd0, 2'd3);
        check("exact_9", 32'(count), 32'd9);
        cyc("exact_2", 0, 0, 1, 8'd0, 2'd3);
        cyc("exact_3", 0, 0, 1, 8'd0, 2'd3);
        cyc("exact_4", 0, 0, 1, 8'd0, 2'd3);
        check("exact_done", 32'(done), 32'd1);
        check("exact_borrow", 32'(borrow), 32'd0);
        cyc("exact_after", 0, 0, 1, 8'd0, 2'd3);
        check("exact_done_drop", 32'(done), 32'd0);

        // Underflow 5 by 2
        cyc("uf_load", 1, 0, 1, 8'd5, 2'd2);
        cyc("uf_1", 0, 0, 1, 8'd0, 2'd2);
        cyc("uf_2", 0, 0, 1, 8'd0, 2'd2);
        check("uf_1left", 32'(count), 32'd1);
        cyc("uf_3", 0, 0, 1, 8'd0, 2'd2);
        check("uf_borrow", 32'(borrow), 32'd1);
        check("uf_count", 32'(count), SAT ? 32'd0 : 32'd255);
        cyc("uf_after", 0, 0, 0, 8'd0, 2'd0);
        check("uf_borrow_held", 32'(borrow), 32'd1);

        // Stalls and a zero step
        cyc("st_load", 1, 0, 0, 8'd4, 2'd1);
        cyc("st_a", 0, 0, 1, 8'd0, 2'd1);
        cyc("st_b", 0, 0, 0, 8'd0, 2'd3);
        cyc("st_c", 0, 0, 1, 8'd0, 2'd1);
        cyc("st_d", 0, 0, 0, 8'd0, 2'd2);
        cyc("st_z", 0, 0, 1, 8'd0, 2'd0);
        check("st_zero_step", 32'(count), 32'd2);
        cyc("st_e", 0, 0, 1, 8'd0, 2'd1);
        check("st_notdone", 32'(done), 32'd0);
        cyc("st_f", 0, 0, 0, 8'd0, 2'd1);
        cyc("st_g", 0, 0, 1, 8'd0, 2'd1);
        check("st_done", 32'(done), 32'd1);

        // Zero load, then back-to-back load in the DONE cycle
        cyc("z_idle", 0, 0, 0, 8'd0, 2'd0);
        cyc("z_load", 1, 0, 1, 8'd0, 2'd1);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        cyc("z_b2b", 1, 0, 1, 8'd2, 2'd1);
        check("z_b2b_count", 32'(count), 32'd2);
        check("z_b2b_busy", 32'(busy), 32'd1);
        cyc("z_r1", 0, 0, 1, 8'd0, 2'd1);
        cyc("z_r2", 0, 0, 1, 8'd0, 2'd1);

        // start ignored while busy; clr wins over start and en
        cyc("c_load", 1, 0, 1, 8'd10, 2'd1);
        cyc("c_r1", 0, 0, 1, 8'd0, 2'd1);
        cyc("c_ign", 1, 0, 1, 8'd50, 2'd1);
        check("c_ign_count", 32'(count), 32'd8);
        cyc("c_clr", 1, 1, 1, 8'd50, 2'd1);
        check("c_clr_count", 32'(count), 32'd8);
        check("c_clr_busy", 32'(busy), 32'd0);
        check("c_clr_done", 32'(done), 32'd0);
        cyc("c_idle", 0, 0, 1, 8'd0, 2'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rnd",
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 40)),
                2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
